rst_seq_ctrl: RTL and testbench

Reset and start-up sequencer for the microcontroller top level. It runs on the PLL output clock and holds the whole system in reset until the PLL has had time to settle. It then releases the debug/power-on domain and the AHB system domain in order. After start-up it services an external reset button, a core software reset request (SYSRESETREQ) and core lockup, and records the cause of every reset in a sticky register.

---
 rtl/rst_seq_pkg.sv | 32 +++
 rtl/rst_seq_ctrl_if.sv | 40 ++++
 rtl/rst_btn_debounce.sv | 47 ++++
 rtl/rst_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_rst_seq_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset/start-up sequencer.
// Holds the FSM state type, reset-cause bit positions and the per-state reset levels.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        POR_WAIT = 3'd0,
        POR_REL  = 3'd1,
        RUN      = 3'd2,
        SYS_RST  = 3'd3,
        FULL_RST = 3'd4
    } rst_state_e;

    localparam int CAUSE_W      = 4;
    localparam int CAUSE_POR    = 0;
    localparam int CAUSE_BTN    = 1;
    localparam int CAUSE_SW     = 2;
    localparam int CAUSE_LOCKUP = 3;

    localparam logic [CAUSE_W-1:0] CAUSE_RESET = CAUSE_W'(1) << CAUSE_POR;

    // {poreset_n, hresetn, sys_ready} presented while sitting in a given state
    function automatic logic [2:0] state_outs(rst_state_e s);
        logic [2:0] o;
        case (s)
            POR_REL, SYS_RST: o = 3'b100;
            RUN:              o = 3'b111;
            default:          o = 3'b000;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// Reset request / reset output bundle between the sequencer and the system top level.
// The sequencer connects through the slave modport; the system side uses master.
interface rst_seq_ctrl_if;
    import rst_seq_pkg::*;

    logic               btn_rst_n;
    logic               sysresetreq;
    logic               lockup;
    logic               lockup_rst_en;
    logic               rst_cause_clr;
    logic               poreset_n;
    logic               hresetn;
    logic               sys_ready;
    logic [CAUSE_W-1:0] rst_cause;

    modport master (
        output btn_rst_n,
        output sysresetreq,
        output lockup,
        output lockup_rst_en,
        output rst_cause_clr,
        input  poreset_n,
        input  hresetn,
        input  sys_ready,
        input  rst_cause
    );

    modport slave (
        input  btn_rst_n,
        input  sysresetreq,
        input  lockup,
        input  lockup_rst_en,
        input  rst_cause_clr,
        output poreset_n,
        output hresetn,
        output sys_ready,
        output rst_cause
    );

endinterface

// File: rtl/rst_btn_debounce.sv
// Reset-button synchroniser and debouncer: one btn_evt pulse per qualified press.
// After a pulse the debouncer stays disarmed until the button is seen released.
module rst_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int CNT_W           = 16
) (
    input  logic CLK,
    input  logic RESET,
    input  logic btn_rst_n,
    output logic btn_evt
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_meta;
    logic             btn_s;
    logic             armed;
    logic [CNT_W-1:0] dcnt;

    // Synchroniser clears to "pressed" so a button held through reset cannot re-arm early.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
            armed    <= 1'b0;
            dcnt     <= '0;
            btn_evt  <= 1'b0;
        end else begin
            btn_meta <= btn_rst_n;
            btn_s    <= btn_meta;
            btn_evt  <= 1'b0;
            if (btn_s) begin
                dcnt  <= '0;
                armed <= 1'b1;
            end else if (armed) begin
                if (dcnt == DEB_LAST) begin
                    btn_evt <= 1'b1;
                    armed   <= 1'b0;
                    dcnt    <= '0;
                end else begin
                    dcnt <= dcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Start-up and runtime reset sequencer: PLL settle, ordered domain release,
// button / software / lockup resets and a sticky reset-cause register.
//
// state    | meaning
// POR_WAIT | both resets low, waiting SETTLE_CYCLES for the PLL
// POR_REL  | debug domain released, AHB domain held HOLD_CYCLES
// RUN      | both domains running, sys_ready high
// SYS_RST  | AHB domain reset only, debug survives
// FULL_RST | button reset: both domains low for HOLD_CYCLES, no PLL wait
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 4096,
    parameter int HOLD_CYCLES     = 16,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int CNT_W           = 16
) (
    input logic           CLK,
    input logic           RESET,
    rst_seq_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

    rst_state_e         state;
    logic [CNT_W-1:0]   cnt;
    logic               poreset_q;
    logic               hresetn_q;
    logic               ready_q;
    logic [CAUSE_W-1:0] cause_q;
    logic [CAUSE_W-1:0] cause_set;
    logic [CAUSE_W-1:0] cause_nxt;
    logic               btn_evt;
    logic               sw_hit;
    logic               lock_hit;
    logic               sys_trig;

    rst_btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_btn_debounce (
        .CLK       (CLK),
        .RESET     (RESET),
        .btn_rst_n (bus.btn_rst_n),
        .btn_evt   (btn_evt)
    );

    // A button event in RUN pre-empts the system reset, so sw/lockup causes are not logged then.
    always_comb begin
        sw_hit                  = bus.sysresetreq;
        lock_hit                = bus.lockup & bus.lockup_rst_en;
        sys_trig                = (state == RUN) && !btn_evt && (sw_hit || lock_hit);
        cause_set               = '0;
        cause_set[CAUSE_BTN]    = btn_evt;
        cause_set[CAUSE_SW]     = sys_trig & sw_hit;
        cause_set[CAUSE_LOCKUP] = sys_trig & lock_hit;
        cause_nxt               = (bus.rst_cause_clr ? '0 : cause_q) | cause_set;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= POR_WAIT;
            cnt       <= '0;
            poreset_q <= 1'b0;
            hresetn_q <= 1'b0;
            ready_q   <= 1'b0;
            cause_q   <= CAUSE_RESET;
        end else begin
            cause_q <= cause_nxt;
            case (state)
                POR_WAIT: begin
                    if (cnt == SETTLE_LAST) begin
                        state <= POR_REL;
                        cnt   <= '0;
                        {poreset_q, hresetn_q, ready_q} <= state_outs(POR_REL);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                POR_REL: begin
                    if (btn_evt) begin
                        state <= FULL_RST;
                        cnt   <= '0;
                        {poreset_q, hresetn_q, ready_q} <= state_outs(FULL_RST);
                    end else if (cnt == HOLD_LAST) begin
                        state <= RUN;
                        cnt   <= '0;
                        {poreset_q, hresetn_q, ready_q} <= state_outs(RUN);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (btn_evt) begin
                        state <= FULL_RST;
                        cnt   <= '0;
                        {poreset_q, hresetn_q, ready_q} <= state_outs(FULL_RST);
                    end else if (sys_trig) begin
                        state <= SYS_RST;
                        cnt   <= '0;
                        {poreset_q, hresetn_q, ready_q} <= state_outs(SYS_RST);
                    end
                end
                SYS_RST: begin
                    // Counter saturates so a long-held request keeps the AHB domain in reset.
                    if ((cnt >= HOLD_LAST) && !bus.sysresetreq) begin
                        state <= RUN;
                        cnt   <= '0;
                        {poreset_q, hresetn_q, ready_q} <= state_outs(RUN);
                    end else if (cnt < HOLD_LAST) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FULL_RST: begin
                    if (cnt == HOLD_LAST) begin
                        state <= POR_REL;
                        cnt   <= '0;
                        {poreset_q, hresetn_q, ready_q} <= state_outs(POR_REL);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= POR_WAIT;
                    cnt   <= '0;
                    {poreset_q, hresetn_q, ready_q} <= state_outs(POR_WAIT);
                end
            endcase
        end
    end

    assign bus.poreset_n = poreset_q;
    assign bus.hresetn   = hresetn_q;
    assign bus.sys_ready = ready_q;
    assign bus.rst_cause = cause_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: vector table, hand-written button/reset sequences and
// a randomized run compared against a cycle-level reference model.
module tb_rst_seq_ctrl;

    localparam int S = 8;
    localparam int H = 4;
    localparam int D = 4;

    logic clk;
    logic rst;

    rst_seq_ctrl_if bus ();

    rst_seq_ctrl #(
        .SETTLE_CYCLES   (S),
        .HOLD_CYCLES     (H),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (16)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string      nm;
        bit         r, b, q, l, e, c;
        logic [6:0] exp;
    } vec_t;

    vec_t vq[$];

    // Reference model: phase name plus edges spent in it, button history as plain counts
    string      m_phase;
    int         m_t;
    bit         m_s1, m_s2, m_armed, m_evt;
    int         m_low;
    logic [3:0] m_cause;

    task automatic model_step();
        bit         evt;
        logic [3:0] c;
        bit         lk;
        if (rst) begin
            m_phase = "POR_WAIT"; m_t = 0; m_cause = 4'b0001;
            m_s1 = 0; m_s2 = 0; m_armed = 0; m_evt = 0; m_low = 0;
            return;
        end
        evt = m_evt;
        lk  = bus.lockup && bus.lockup_rst_en;
        c   = bus.rst_cause_clr ? 4'b0000 : m_cause;
        if (evt) c[1] = 1'b1;
        case (m_phase)
            "POR_WAIT": begin
                m_t++;
                if (m_t == S) begin m_phase = "POR_REL"; m_t = 0; end
            end
            "POR_REL": begin
                if (evt) begin m_phase = "FULL_RST"; m_t = 0; end
                else begin
                    m_t++;
                    if (m_t == H) begin m_phase = "RUN"; m_t = 0; end
                end
            end
            "RUN": begin
                if (evt) begin m_phase = "FULL_RST"; m_t = 0; end
                else if (bus.sysresetreq || lk) begin
                    if (bus.sysresetreq) c[2] = 1'b1;
                    if (lk) c[3] = 1'b1;
                    m_phase = "SYS_RST"; m_t = 0;
                end
            end
            "SYS_RST": begin
                m_t++;
                if (m_t >= H && !bus.sysresetreq) begin m_phase = "RUN"; m_t = 0; end
            end
            default: begin
                m_t++;
                if (m_t == H) begin m_phase = "POR_REL"; m_t = 0; end
            end
        endcase
        m_cause = c;
        m_evt = 0;
        if (m_s2) begin
            m_low = 0; m_armed = 1;
        end else if (m_armed) begin
            m_low++;
            if (m_low == D) begin m_evt = 1; m_armed = 0; m_low = 0; end
        end
        m_s2 = m_s1;
        m_s1 = bus.btn_rst_n;
    endtask

    function automatic logic [6:0] model_outs();
        bit por, run;
        por = !(m_phase == "POR_WAIT" || m_phase == "FULL_RST");
        run = (m_phase == "RUN");
        return {por, run, run, m_cause};
    endfunction

    function automatic logic [6:0] dut_outs();
        return {bus.poreset_n, bus.hresetn, bus.sys_ready, bus.rst_cause};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit b, input bit q, input bit l, input bit e, input bit c);
        rst               = r;
        bus.btn_rst_n     = b;
        bus.sysresetreq   = q;
        bus.lockup        = l;
        bus.lockup_rst_en = e;
        bus.rst_cause_clr = c;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    function automatic void v(input string nm, input bit r, input bit q, input bit l, input bit e,
                              input bit c, input logic [2:0] o, input logic [3:0] cause);
        vec_t x;
        x.nm = nm; x.r = r; x.b = 1'b1; x.q = q; x.l = l; x.e = e; x.c = c;
        x.exp = {o, cause};
        vq.push_back(x);
    endfunction

    // Power-on from the edge after RESET: poreset_n at edge S, hresetn/sys_ready at S+H
    task automatic por_seq(input string nm);
        for (int e = 1; e <= S + H; e++) begin
            cyc(0, 1, 0, 0, 0, 0);
            chk($sformatf("%s_edge%0d", nm, e), dut_outs(),
                {(e >= S) ? 1'b1 : 1'b0, (e >= S + H) ? 2'b11 : 2'b00, 4'b0001});
        end
    endtask

    task automatic btn_press(input string nm, input int low_cycles, input int total, output int falls);
        logic [2:0] exp_o;
        bit         prev_por;
        int         lat;
        lat      = 2 + D + 1;
        falls    = 0;
        prev_por = bus.poreset_n;
        for (int i = 1; i <= total; i++) begin
            cyc(0, (i <= low_cycles) ? 1'b0 : 1'b1, 0, 0, 0, 0);
            exp_o[2] = !(i >= lat && i <= lat + H - 1);
            exp_o[1] = !(i >= lat && i <= lat + 2 * H - 1);
            exp_o[0] = exp_o[1];
            chk($sformatf("%s_i%0d", nm, i), {bus.poreset_n, bus.hresetn, bus.sys_ready}, exp_o);
            if (prev_por && !bus.poreset_n) falls++;
            prev_por = bus.poreset_n;
        end
    endtask

    initial begin
        int         falls;
        bit         drop;
        bit         btn_lvl;
        int         btn_left;

        rst = 1'b1;
        bus.btn_rst_n = 1'b1; bus.sysresetreq = 1'b0; bus.lockup = 1'b0;
        bus.lockup_rst_en = 1'b0; bus.rst_cause_clr = 1'b0;

        // ---- vector table ----
        for (int i = 0; i < 3; i++) v("por_reset", 1, 0, 0, 0, 0, 3'b000, 4'b0001);
        for (int e = 1; e <= S + H; e++)
            v($sformatf("por_e%0d", e), 0, 0, 0, 0, 0,
              {(e >= S) ? 1'b1 : 1'b0, (e >= S + H) ? 2'b11 : 2'b00}, 4'b0001);
        v("idle", 0, 0, 0, 0, 0, 3'b111, 4'b0001);
        v("idle", 0, 0, 0, 0, 0, 3'b111, 4'b0001);
        v("sw_enter", 0, 1, 0, 0, 0, 3'b100, 4'b0101);
        for (int i = 0; i < H - 1; i++) v("sw_hold", 0, 0, 0, 0, 0, 3'b100, 4'b0101);
        v("sw_exit", 0, 0, 0, 0, 0, 3'b111, 4'b0101);
        v("clr_race", 0, 1, 0, 0, 1, 3'b100, 4'b0100);
        for (int i = 0; i < H - 1; i++) v("clr_race_hold", 0, 0, 0, 0, 0, 3'b100, 4'b0100);
        v("clr_race_exit", 0, 0, 0, 0, 0, 3'b111, 4'b0100);
        v("clr_alone", 0, 0, 0, 0, 1, 3'b111, 4'b0000);
        v("lock_dis", 0, 0, 1, 0, 0, 3'b111, 4'b0000);
        v("lock_dis_idle", 0, 0, 0, 0, 0, 3'b111, 4'b0000);
        v("lock_en", 0, 0, 1, 1, 0, 3'b100, 4'b1000);
        for (int i = 0; i < H - 1; i++) v("lock_hold", 0, 0, 0, 1, 0, 3'b100, 4'b1000);
        v("lock_exit", 0, 0, 0, 1, 0, 3'b111, 4'b1000);
        v("sw_lock", 0, 1, 1, 1, 1, 3'b100, 4'b1100);
        for (int i = 0; i < H - 1; i++) v("sw_lock_hold", 0, 0, 0, 1, 0, 3'b100, 4'b1100);
        v("sw_lock_exit", 0, 0, 0, 1, 0, 3'b111, 4'b1100);
        for (int i = 0; i < 10; i++) v($sformatf("sw_long%0d", i), 0, 1, 0, 0, 0, 3'b100, 4'b1100);
        v("sw_long_exit", 0, 0, 0, 0, 0, 3'b111, 4'b1100);
        v("idle", 0, 0, 0, 0, 0, 3'b111, 4'b1100);

        foreach (vq[i]) begin
            cyc(vq[i].r, vq[i].b, vq[i].q, vq[i].l, vq[i].e, vq[i].c);
            chk(vq[i].nm, dut_outs(), vq[i].exp);
        end

        // ---- button glitch shorter than the debounce window ----
        cyc(0, 1, 0, 0, 0, 1);
        drop = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            cyc(0, (i <= D - 1) ? 1'b0 : 1'b1, 0, 0, 0, 0);
            if (!bus.poreset_n || !bus.hresetn) drop = 1'b1;
        end
        chk("btn_glitch_no_reset", drop, 1'b0);
        chk("btn_glitch_cause", bus.rst_cause, 4'b0000);

        // ---- long press: one full reset, none while still held ----
        btn_press("btn_long", 20, 40, falls);
        chk("btn_long_single_event", falls, 1);
        chk("btn_long_cause", bus.rst_cause, 4'b0010);

        // ---- second press after release fires again ----
        btn_press("btn_second", 20, 40, falls);
        chk("btn_second_event", falls, 1);

        // ---- RESET during POR_REL ----
        cyc(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < S + 1; i++) cyc(0, 1, 0, 0, 0, 0);
        chk("in_por_rel", dut_outs(), {3'b100, 4'b0001});
        cyc(0, 1, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 0);
        chk("rst_mid_por_rel", dut_outs(), {3'b000, 4'b0001});
        por_seq("reseq_por_rel");

        // ---- RESET during SYS_RST ----
        cyc(0, 1, 1, 0, 0, 0);
        chk("enter_sys_rst", dut_outs(), {3'b100, 4'b0101});
        cyc(0, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        chk("rst_mid_sys_rst", dut_outs(), {3'b000, 4'b0001});
        por_seq("reseq_sys_rst");

        // ---- randomized run against the reference model ----
        btn_lvl  = 1'b1;
        btn_left = 5;
        for (int i = 0; i < 3000; i++) begin
            if (btn_left == 0) begin
                btn_lvl  = ~btn_lvl;
                btn_left = btn_lvl ? $urandom_range(2, 20)
                         : (($urandom_range(0, 1) == 0) ? $urandom_range(1, D) : $urandom_range(D, 25));
            end
            btn_left--;
            cyc(($urandom_range(0, 299) == 0), btn_lvl, ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
            chk($sformatf("random_%0d", i), dut_outs(), model_outs());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
